// File: rtl/rv32v_types_pkg.sv
// Shared types for the rv32v element-counter dispatch path.
// Slot lifecycle encoding and the default vector-length field width.
package rv32v_types_pkg;

    localparam int VL_WIDTH_DEF = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        RUN    = 3'd2,
        RETIRE = 3'd3,
        FAULT  = 3'd4
    } slot_state_t;

endpackage

// File: rtl/slot_order_fifo.sv
// Issue-order FIFO of slot ids; the head is the next op allowed to retire.
// Flush empties it in one cycle and takes priority over push and pop.
module slot_order_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 1
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic             empty_o,
    output logic             full_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_q, wr_d;
    logic [PW-1:0]    rd_q, rd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_push, do_pop;

    // Wrapping increment so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign head_o  = mem_q[rd_q];

    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (flush_i) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (do_push) wr_d = ptr_inc(wr_q);
            if (do_pop)  rd_d = ptr_inc(rd_q);
            cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
            if (do_push) mem_q[wr_q] <= data_i;
        end
    end

endmodule

// File: rtl/element_counter_dispatch.sv
// Dispatcher in front of the rv32v element-counter bank: allocates counter slots to
// decoded vector ops, drives per-slot start/clear/stall, and retires ops in issue order.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | slot free, may be allocated to the next accepted op
// START  | one-cycle cnt_start pulse, vl/vstart already latched
// RUN    | counter active; cnt_stall follows pipe_stall
// RETIRE | op finished (or was empty); waits to reach the order FIFO head
// FAULT  | element exception; offset latched, waits for in-order retirement
module element_counter_dispatch
    import rv32v_types_pkg::*;
#(
    parameter  int NUM_COUNTERS = 2,
    parameter  int VL_WIDTH     = VL_WIDTH_DEF,
    localparam int ID_WIDTH     = (NUM_COUNTERS > 1) ? $clog2(NUM_COUNTERS) : 1
) (
    input  logic                             CLK,
    input  logic                             nRST,
    input  logic                             issue_valid,
    output logic                             issue_ready,
    input  logic [VL_WIDTH-1:0]              issue_vl,
    input  logic [VL_WIDTH-1:0]              issue_vstart,
    input  logic                             flush,
    input  logic                             pipe_stall,
    output logic [NUM_COUNTERS-1:0]          cnt_start,
    output logic [NUM_COUNTERS-1:0]          cnt_clear,
    output logic [NUM_COUNTERS-1:0]          cnt_stall,
    output logic [NUM_COUNTERS*VL_WIDTH-1:0] cnt_vl,
    output logic [NUM_COUNTERS*VL_WIDTH-1:0] cnt_vstart,
    input  logic [NUM_COUNTERS-1:0]          cnt_done,
    input  logic [NUM_COUNTERS-1:0]          fault_valid,
    input  logic [NUM_COUNTERS*VL_WIDTH-1:0] fault_offset,
    output logic                             retire_valid,
    input  logic                             retire_ready,
    output logic [ID_WIDTH-1:0]              retire_id,
    output logic                             retire_fault,
    output logic [VL_WIDTH-1:0]              retire_vstart
);

    slot_state_t             state_w [NUM_COUNTERS];
    logic [VL_WIDTH-1:0]     off_w   [NUM_COUNTERS];
    logic [NUM_COUNTERS-1:0] idle_w;
    logic [NUM_COUNTERS-1:0] sel_w;
    logic [ID_WIDTH-1:0]     alloc_id;
    logic [ID_WIDTH-1:0]     head_id;
    slot_state_t             head_state;
    logic                    fifo_empty, fifo_full;
    logic                    accept, pop, issue_empty;

    assign issue_ready = (|idle_w) && !fifo_full && !flush;
    assign accept      = issue_valid && issue_ready;
    assign issue_empty = (issue_vstart >= issue_vl);

    // Lowest-index free slot wins; scanning downward lets the last hit be the lowest.
    always_comb begin
        sel_w    = '0;
        alloc_id = '0;
        for (int i = NUM_COUNTERS - 1; i >= 0; i--) begin
            if (idle_w[i]) begin
                sel_w    = '0;
                sel_w[i] = 1'b1;
                alloc_id = ID_WIDTH'(i);
            end
        end
    end

    slot_order_fifo #(
        .DEPTH (NUM_COUNTERS),
        .WIDTH (ID_WIDTH)
    ) u_order (
        .CLK     (CLK),
        .nRST    (nRST),
        .push_i  (accept),
        .data_i  (alloc_id),
        .pop_i   (pop),
        .flush_i (flush),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .head_o  (head_id)
    );

    assign head_state    = state_w[head_id];
    assign retire_valid  = !fifo_empty && (head_state == RETIRE || head_state == FAULT);
    assign retire_fault  = retire_valid && (head_state == FAULT);
    assign retire_id     = retire_valid ? head_id : '0;
    assign retire_vstart = retire_fault ? off_w[head_id] : '0;
    assign pop           = retire_valid && retire_ready && !flush;

    for (genvar g = 0; g < NUM_COUNTERS; g++) begin : g_slot
        slot_state_t         state_q, state_d;
        logic [VL_WIDTH-1:0] vl_q, vstart_q, off_q;
        logic                clear_q;
        logic                take, retire_me, fault_hit;

        assign take      = accept && sel_w[g];
        assign retire_me = pop && (head_id == ID_WIDTH'(g));
        assign fault_hit = (state_q == RUN) && fault_valid[g];

        always_comb begin
            state_d = state_q;
            if (flush) begin
                state_d = IDLE;
            end else begin
                case (state_q)
                    IDLE:          if (take) state_d = issue_empty ? RETIRE : START;
                    START:         state_d = RUN;
                    RUN: begin
                        // Fault has priority over a same-cycle done.
                        if (fault_valid[g])   state_d = FAULT;
                        else if (cnt_done[g]) state_d = RETIRE;
                    end
                    RETIRE, FAULT: if (retire_me) state_d = IDLE;
                    default:       state_d = IDLE;
                endcase
            end
        end

        always_ff @(posedge CLK or negedge nRST) begin
            if (!nRST) begin
                state_q  <= IDLE;
                vl_q     <= '0;
                vstart_q <= '0;
                off_q    <= '0;
                clear_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                clear_q <= flush ? (state_q != IDLE) : fault_hit;
                if (take) begin
                    vl_q     <= issue_vl;
                    vstart_q <= issue_vstart;
                end
                if (fault_hit && !flush) off_q <= fault_offset[g*VL_WIDTH +: VL_WIDTH];
            end
        end

        assign state_w[g]                          = state_q;
        assign off_w[g]                            = off_q;
        assign idle_w[g]                           = (state_q == IDLE);
        assign cnt_start[g]                        = (state_q == START);
        assign cnt_clear[g]                        = clear_q;
        assign cnt_stall[g]                        = (state_q == RUN) && pipe_stall;
        assign cnt_vl[g*VL_WIDTH +: VL_WIDTH]      = vl_q;
        assign cnt_vstart[g*VL_WIDTH +: VL_WIDTH]  = vstart_q;
    end

endmodule

// File: tb/tb_element_counter_dispatch.sv
// Bench for element_counter_dispatch: directed scenarios then random traffic, all
// checked against a per-op timestamp model with an in-order retirement queue.
module tb_element_counter_dispatch;

    localparam int N = 2;
    localparam int W = 8;

    logic           CLK = 1'b0;
    logic           nRST;
    logic           issue_valid, issue_ready;
    logic [W-1:0]   issue_vl, issue_vstart;
    logic           flush, pipe_stall;
    logic [N-1:0]   cnt_start, cnt_clear, cnt_stall, cnt_done, fault_valid;
    logic [N*W-1:0] cnt_vl, cnt_vstart, fault_offset;
    logic           retire_valid, retire_ready, retire_fault;
    logic [0:0]     retire_id;
    logic [W-1:0]   retire_vstart;

    always #5 CLK = ~CLK;

    element_counter_dispatch #(.NUM_COUNTERS(N), .VL_WIDTH(W)) dut (
        .CLK           (CLK),
        .nRST          (nRST),
        .issue_valid   (issue_valid),
        .issue_ready   (issue_ready),
        .issue_vl      (issue_vl),
        .issue_vstart  (issue_vstart),
        .flush         (flush),
        .pipe_stall    (pipe_stall),
        .cnt_start     (cnt_start),
        .cnt_clear     (cnt_clear),
        .cnt_stall     (cnt_stall),
        .cnt_vl        (cnt_vl),
        .cnt_vstart    (cnt_vstart),
        .cnt_done      (cnt_done),
        .fault_valid   (fault_valid),
        .fault_offset  (fault_offset),
        .retire_valid  (retire_valid),
        .retire_ready  (retire_ready),
        .retire_id     (retire_id),
        .retire_fault  (retire_fault),
        .retire_vstart (retire_vstart)
    );

    int n_pass = 0, n_total = 0, n_fail = 0;

    // Model: each slot holds an op accepted at cycle acc[i]; the op is "counting" from
    // acc+2 until done/fault; clear is expected at the cycle stored in clr[i].
    bit busy [N], emp [N], ended [N], flt [N];
    int acc [N], off [N], mvl [N], mvs [N], clr [N];
    int ord [$];
    int cyc = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            busy[i] = 0; ended[i] = 0; flt[i] = 0; emp[i] = 0; clr[i] = -10;
        end
        ord.delete();
    endtask

    task automatic idle();
        issue_valid = 0; issue_vl = '0; issue_vstart = '0; flush = 0; pipe_stall = 0;
        cnt_done = '0; fault_valid = '0; fault_offset = '0; retire_ready = 0;
    endtask

    // Caller sets inputs at the falling edge; this checks outputs, advances the model
    // across the next rising edge and returns at the following falling edge.
    task automatic step();
        bit           run [N];
        logic [N-1:0] e_start, e_clear, e_stall;
        bit           e_rv, e_ready, e_f;
        int           e_id, e_vs, slot_new;
        #1;
        e_start = '0; e_clear = '0; e_stall = '0; e_ready = 0;
        for (int i = 0; i < N; i++) begin
            run[i]     = busy[i] && !emp[i] && !ended[i] && (cyc >= acc[i] + 2);
            e_start[i] = busy[i] && !emp[i] && (cyc == acc[i] + 1);
            e_stall[i] = run[i] && pipe_stall;
            e_clear[i] = (clr[i] == cyc);
            if (!busy[i]) e_ready = 1;
        end
        e_ready = e_ready && !flush;
        e_rv = (ord.size() > 0) && (emp[ord[0]] || ended[ord[0]]);
        e_id = e_rv ? ord[0] : 0;
        e_f  = e_rv && flt[ord[0]];
        e_vs = e_f ? off[ord[0]] : 0;

        check("issue_ready", issue_ready, e_ready);
        check("cnt_start", cnt_start, e_start);
        check("cnt_clear", cnt_clear, e_clear);
        check("cnt_stall", cnt_stall, e_stall);
        check("retire_valid", retire_valid, e_rv);
        check("retire_id", retire_id, e_id);
        check("retire_fault", retire_fault, e_f);
        check("retire_vstart", retire_vstart, e_vs);
        for (int i = 0; i < N; i++) begin
            if (busy[i]) begin
                check($sformatf("cnt_vl%0d", i), cnt_vl[i*W +: W], mvl[i]);
                check($sformatf("cnt_vstart%0d", i), cnt_vstart[i*W +: W], mvs[i]);
            end
        end

        slot_new = -1;
        if (issue_valid && e_ready)
            for (int i = N - 1; i >= 0; i--) if (!busy[i]) slot_new = i;
        if (flush) begin
            for (int i = 0; i < N; i++) if (busy[i]) begin clr[i] = cyc + 1; busy[i] = 0; end
            ord.delete();
        end else begin
            if (e_rv && retire_ready) begin
                busy[ord[0]] = 0;
                void'(ord.pop_front());
            end
            for (int i = 0; i < N; i++) begin
                if (run[i] && fault_valid[i]) begin
                    ended[i] = 1; flt[i] = 1; off[i] = fault_offset[i*W +: W]; clr[i] = cyc + 1;
                end else if (run[i] && cnt_done[i]) begin
                    ended[i] = 1;
                end
            end
            if (slot_new >= 0) begin
                busy[slot_new] = 1; acc[slot_new] = cyc; ended[slot_new] = 0; flt[slot_new] = 0;
                emp[slot_new] = (issue_vstart >= issue_vl);
                mvl[slot_new] = issue_vl; mvs[slot_new] = issue_vstart;
                ord.push_back(slot_new);
            end
        end
        @(posedge CLK);
        cyc++;
        @(negedge CLK);
    endtask

    initial begin
        model_reset();
        idle();
        nRST = 0;
        #12;
        @(negedge CLK);
        nRST = 1;
        step();

        // single op vl=4 on slot 0
        issue_valid = 1; issue_vl = 8'd4; issue_vstart = 8'd0; step();
        idle();
        check("a_start_slot0", cnt_start, 2'b01);
        check("a_vl", cnt_vl[W-1:0], 4);
        step(); step(); step();
        cnt_done = 2'b01; step();
        idle();
        check("a_rv", retire_valid, 1);
        check("a_id", retire_id, 0);
        check("a_fault", retire_fault, 0);
        retire_ready = 1; step(); step();

        // empty ops: vl=0, then vl=5 vstart=5
        idle(); retire_ready = 1; issue_valid = 1; step();
        check("b_no_start0", cnt_start, 2'b00);
        check("b_rv0", retire_valid, 1);
        check("b_id0", retire_id, 0);
        issue_vl = 8'd5; issue_vstart = 8'd5; step();
        issue_valid = 0;
        check("b_no_start1", cnt_start, 2'b00);
        check("b_id1", retire_id, 1);
        step(); step();

        // slot 1 done first; retirement still in issue order
        idle(); issue_valid = 1; issue_vl = 8'd6; step(); step();
        idle(); step();
        cnt_done = 2'b10; step();
        idle(); retire_ready = 1;
        check("c_head_blocks", retire_valid, 0);
        step();
        cnt_done = 2'b01; step();
        cnt_done = 2'b00;
        check("c_first_id", retire_id, 0);
        step();
        check("c_second_rv", retire_valid, 1);
        check("c_second_id", retire_id, 1);
        step();
        idle(); step();

        // fault and done in the same cycle: fault wins
        issue_valid = 1; issue_vl = 8'd8; step();
        idle(); step();
        cnt_done = 2'b01; fault_valid = 2'b01; fault_offset = 16'h0003; step();
        idle();
        check("d_clear", cnt_clear, 2'b01);
        check("d_fault", retire_fault, 1);
        check("d_vstart", retire_vstart, 3);
        retire_ready = 1; step(); step();

        // full: no accept; retire_* held while not ready; accept resumes after pop
        idle(); issue_valid = 1; issue_vl = 8'd3; step(); step();
        idle();
        check("e_full", issue_ready, 0);
        step();
        cnt_done = 2'b11; step();
        idle(); issue_valid = 1; issue_vl = 8'd2;
        for (int k = 0; k < 3; k++) begin
            check("e_hold_rv", retire_valid, 1);
            check("e_hold_id", retire_id, 0);
            step();
        end
        retire_ready = 1; step();
        check("e_resume", issue_ready, 1);
        step();
        idle(); flush = 1; step();
        idle(); step();

        // flush with both slots running and an op offered
        issue_valid = 1; issue_vl = 8'd10; step(); step();
        idle(); step();
        flush = 1; issue_valid = 1; pipe_stall = 1; step();
        idle();
        check("f_clear", cnt_clear, 2'b11);
        check("f_rv", retire_valid, 0);
        check("f_no_start", cnt_start, 2'b00);
        step();

        // asynchronous reset mid-run
        issue_valid = 1; issue_vl = 8'd9; issue_vstart = 8'd1; step();
        idle(); pipe_stall = 1; step(); step();
        #2 nRST = 0;
        #1;
        check("r_start", cnt_start, 0);
        check("r_clear", cnt_clear, 0);
        check("r_stall", cnt_stall, 0);
        check("r_vl", cnt_vl, 0);
        check("r_vstart", cnt_vstart, 0);
        check("r_rv", retire_valid, 0);
        model_reset();
        @(negedge CLK);
        nRST = 1;
        idle(); step();

        // random traffic
        for (int k = 0; k < 3000; k++) begin
            issue_valid  = ($urandom_range(9) < 6);
            issue_vl     = W'($urandom_range(7));
            issue_vstart = W'($urandom_range(7));
            flush        = ($urandom_range(39) == 0);
            pipe_stall   = ($urandom_range(9) < 3);
            retire_ready = ($urandom_range(9) < 6);
            for (int i = 0; i < N; i++) begin
                cnt_done[i]            = ($urandom_range(3) == 0);
                fault_valid[i]         = ($urandom_range(9) == 0);
                fault_offset[i*W +: W] = W'($urandom_range(255));
            end
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
